snax_dream_csr_manager: RTL and testbench
=========================================

SNAX_DREAM_CSR_MANAGER -- requirements
Module: snax_dream_csr_manager

Interface
REQ-001 SHALL have parameter RegRWCount, default 3: number of read-write configuration registers driven to the accelerator.
REQ-002 SHALL have parameter RegROCount, default 2: number of read-only status registers sampled from the accelerator.
REQ-003 SHALL have parameter RegDataWidth, default 32: register and CSR data width.
REQ-004 SHALL have parameter RegAddrWidth, default 32: CSR request address width.
REQ-005 SHALL have ports, one per line:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- csr_req_addr_i  in  RegAddrWidth  register index (word index, not byte).
- csr_req_data_i  in  RegDataWidth  write data.
- csr_req_write_i  in  1  1 = write, 0 = read.
- csr_req_valid_i / csr_req_ready_o  in / out  1  request handshake.
- csr_rsp_data_o  out  RegDataWidth  read data.
- csr_rsp_valid_o / csr_rsp_ready_i  out / in  1  response handshake.
- csr_reg_set_o  out  RegRWCount x RegDataWidth  configuration to accelerator.
- csr_reg_set_valid_o / csr_reg_set_ready_i  out / in  1  launch handshake.
- csr_reg_ro_set_i  in  RegROCount x RegDataWidth  accelerator status.

Function
REQ-006 SHALL use the address map: 0..RegRWCount-1 RW regs; RegRWCount..RegRWCount+RegROCount-1 RO regs; S = RegRWCount+RegROCount start/status reg.
REQ-007 SHALL transfer a request when csr_req_valid_i and csr_req_ready_o are both high in the same cycle.
REQ-008 SHALL update an RW reg on the cycle after an accepted write to its address; csr_reg_set_o SHALL always equal the RW register contents.
REQ-009 SHALL ignore writes to RO addresses and to out-of-range addresses; reads of out-of-range addresses SHALL return 0.
REQ-010 SHALL have a two-state FSM: IDLE and LAUNCH.
REQ-011 SHALL move IDLE -> LAUNCH on an accepted write to S with data bit0 = 1; a write to S with bit0 = 0 SHALL have no effect.
REQ-012 SHALL assert csr_reg_set_valid_o only in LAUNCH, and SHALL move LAUNCH -> IDLE in the cycle csr_reg_set_ready_i is high.
REQ-013 SHALL hold csr_req_ready_o low for writes to RW addresses while in LAUNCH, keeping csr_reg_set_o stable under valid; reads and writes to S SHALL still be accepted in LAUNCH; writes to S SHALL have no effect in LAUNCH.
REQ-014 SHALL produce a response only for reads, with csr_rsp_valid_o high exactly one cycle after acceptance; the data SHALL be the RW reg, the RO input sampled at acceptance, or, for S, {0, busy}, where busy = (state == LAUNCH).
REQ-015 SHALL hold csr_rsp_valid_o and csr_rsp_data_o stable until csr_rsp_ready_i is high; csr_req_ready_o SHALL be low while a response is held unaccepted, except in the cycle it is accepted.
REQ-016 SHALL, if a launch write and csr_reg_set_ready_i coincide in IDLE, enter LAUNCH; ready SHALL be sampled only from LAUNCH, giving a minimum valid duration of one cycle.

Reset
REQ-017 SHALL, when rst_ni is low at a clock edge, clear all RW regs to 0, set state to IDLE, and drive csr_reg_set_valid_o = 0, csr_rsp_valid_o = 0, and csr_rsp_data_o = 0.
REQ-018 SHALL, if reset occurs mid-launch or with a response pending, abort both without a handshake; csr_req_ready_o SHALL be 0 during reset and 1 in the first cycle after it.

Configuration
REQ-019 SHALL, with SNAX_DREAM_CSR_PERF_EN defined, add a 32-bit read-only counter at address S+1 that increments every cycle in LAUNCH, clears on each IDLE -> LAUNCH transition and at reset, and saturates at all-ones.
REQ-020 SHALL, without SNAX_DREAM_CSR_PERF_EN, treat S+1 as out-of-range and generate no counter logic.

Structure
REQ-021 SHALL place the FSM state enum and the address offset constant functions (RO base, S, perf address) in shared package snax_dream_csr_pkg.
REQ-022 SHALL implement the response holding register as sub-module snax_dream_csr_rsp_reg, a one-entry valid/ready register.

Verification
REQ-023 SHALL cover: write 0xA5 to addr 1, then read addr 1 -> csr_reg_set_o[1] = 0xA5 next cycle; response 0xA5 one cycle after acceptance.
REQ-024 SHALL cover: write 1 to S with csr_reg_set_ready_i low for 4 cycles -> valid high for 4 cycles, read S returns 1, a write to addr 0 stalls, then valid drops and the stalled write completes.
REQ-025 SHALL cover: drive csr_reg_ro_set_i[0] = 0x1234 and read addr 3 -> 0x1234; write 0xFF to addr 3 -> ignored; read addr 9 -> 0.
REQ-026 SHALL cover: read with csr_rsp_ready_i low for 3 cycles -> data stable and csr_req_ready_o low throughout; the next request is accepted in the release cycle.
REQ-027 SHALL cover: assert rst_ni low during LAUNCH with a response pending -> all outputs 0 the next cycle; RW regs read 0 after reset.
REQ-028 SHALL cover, with SNAX_DREAM_CSR_PERF_EN: a 5-cycle launch then a read of S+1 -> 5; a second launch clears the counter.

Source files
------------

// File: rtl/snax_dream_csr_pkg.sv
// ============================================================================
// Module   : snax_dream_csr_pkg
// Brief    : Shared FSM state encoding and CSR address-map helpers.
//            Optional feature macro: SNAX_DREAM_CSR_PERF_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

package snax_dream_csr_pkg;

    localparam int unsigned STATE_W = 1;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LAUNCH = 1'b1;

    localparam int unsigned PERF_W = 32;

    function automatic int unsigned ro_base_addr(input int unsigned rw_count);
        return rw_count;
    endfunction

    function automatic int unsigned start_addr(input int unsigned rw_count,
                                               input int unsigned ro_count);
        return rw_count + ro_count;
    endfunction

    function automatic int unsigned perf_addr(input int unsigned rw_count,
                                              input int unsigned ro_count);
        return start_addr(rw_count, ro_count) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snax_dream_csr_rsp_reg.sv
// ============================================================================
// Module   : snax_dream_csr_rsp_reg
// Brief    : One-entry valid/ready holding register for CSR read responses.
//            Optional feature macro: SNAX_DREAM_CSR_PERF_EN (unused here)
// Revision : 1.0
// ============================================================================
`default_nettype none

module snax_dream_csr_rsp_reg #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    output logic [DataWidth-1:0] out_data_o,
    input  logic                 out_ready_i
);

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;

    // Accepts a new entry in the same cycle the held one drains.
    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/snax_dream_csr_manager.sv
// ============================================================================
// Module   : snax_dream_csr_manager
// Brief    : CSR front-end: RW config regs, RO status regs and a launch FSM.
//            Optional feature macro: SNAX_DREAM_CSR_PERF_EN (launch cycle counter)
// Revision : 1.0
// ============================================================================
`default_nettype none

module snax_dream_csr_manager
    import snax_dream_csr_pkg::*;
#(
    parameter int unsigned RegRWCount   = 3,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned RegAddrWidth = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [RegAddrWidth-1:0]                csr_req_addr_i,
    input  logic [RegDataWidth-1:0]                csr_req_data_i,
    input  logic                                   csr_req_write_i,
    input  logic                                   csr_req_valid_i,
    output logic                                   csr_req_ready_o,
    output logic [RegDataWidth-1:0]                csr_rsp_data_o,
    output logic                                   csr_rsp_valid_o,
    input  logic                                   csr_rsp_ready_i,
    output logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_o,
    output logic                                   csr_reg_set_valid_o,
    input  logic                                   csr_reg_set_ready_i,
    input  logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_i
);

    localparam logic [RegAddrWidth-1:0] RW_END  = RegAddrWidth'(RegRWCount);
    localparam logic [RegAddrWidth-1:0] RO_BASE = RegAddrWidth'(ro_base_addr(RegRWCount));
    localparam logic [RegAddrWidth-1:0] S_ADDR  = RegAddrWidth'(start_addr(RegRWCount, RegROCount));

    logic [0:0]                              state_q, state_d;
    logic [RegRWCount-1:0][RegDataWidth-1:0] rw_q, rw_d;
    logic                                    rsp_in_ready;
    logic                                    is_rw_addr;
    logic                                    wr_fire;
    logic                                    rd_fire;
    logic [RegDataWidth-1:0]                 rd_data;

    assign is_rw_addr = (csr_req_addr_i < RW_END);

    // RW writes stall during a launch so the accelerator sees stable config.
    assign csr_req_ready_o = rst_ni & rsp_in_ready &
                             ~((state_q == ST_LAUNCH) & csr_req_write_i & is_rw_addr);

    assign wr_fire = csr_req_valid_i & csr_req_ready_o &  csr_req_write_i;
    assign rd_fire = csr_req_valid_i & csr_req_ready_o & ~csr_req_write_i;

    assign csr_reg_set_o       = rw_q;
    assign csr_reg_set_valid_o = (state_q == ST_LAUNCH);

`ifdef SNAX_DREAM_CSR_PERF_EN
    localparam logic [RegAddrWidth-1:0] PERF_ADDR = RegAddrWidth'(perf_addr(RegRWCount, RegROCount));

    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && (state_d == ST_LAUNCH)) begin
            perf_d = '0;
        end else if ((state_q == ST_LAUNCH) && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < RegRWCount; i++) begin
            if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = rw_q[i];
        end
        for (int unsigned i = 0; i < RegROCount; i++) begin
            if (csr_req_addr_i == RO_BASE + RegAddrWidth'(i)) rd_data = csr_reg_ro_set_i[i];
        end
        if (csr_req_addr_i == S_ADDR) begin
            rd_data = {{(RegDataWidth-1){1'b0}}, (state_q == ST_LAUNCH)};
        end
`ifdef SNAX_DREAM_CSR_PERF_EN
        if (csr_req_addr_i == PERF_ADDR) rd_data = RegDataWidth'(perf_q);
`endif
    end

    always_comb begin
        rw_d    = rw_q;
        state_d = state_q;
        if (wr_fire) begin
            for (int unsigned i = 0; i < RegRWCount; i++) begin
                if (csr_req_addr_i == RegAddrWidth'(i)) rw_d[i] = csr_req_data_i;
            end
        end
        // Launch requests are only honoured from IDLE; ready only from LAUNCH.
        if (state_q == ST_IDLE) begin
            if (wr_fire && (csr_req_addr_i == S_ADDR) && csr_req_data_i[0]) begin
                state_d = ST_LAUNCH;
            end
        end else if (csr_reg_set_ready_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rw_q    <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
        end
    end

    snax_dream_csr_rsp_reg #(
        .DataWidth (RegDataWidth)
    ) u_rsp_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (rd_fire),
        .in_data_i   (rd_data),
        .in_ready_o  (rsp_in_ready),
        .out_valid_o (csr_rsp_valid_o),
        .out_data_o  (csr_rsp_data_o),
        .out_ready_i (csr_rsp_ready_i)
    );

endmodule

`default_nettype wire

// File: tb/tb_snax_dream_csr_manager.sv
// ============================================================================
// Module   : tb_snax_dream_csr_manager
// Brief    : Directed self-checking bench for snax_dream_csr_manager.
//            Optional feature macro: SNAX_DREAM_CSR_PERF_EN (adds counter checks)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snax_dream_csr_manager;

    localparam int unsigned RW_N = 3;
    localparam int unsigned RO_N = 2;
    localparam logic [31:0] S_ADR    = 32'd5;
    localparam logic [31:0] PERF_ADR = 32'd6;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [31:0]            csr_req_addr_i = '0;
    logic [31:0]            csr_req_data_i = '0;
    logic                   csr_req_write_i = 1'b0;
    logic                   csr_req_valid_i = 1'b0;
    logic                   csr_req_ready_o;
    logic [31:0]            csr_rsp_data_o;
    logic                   csr_rsp_valid_o;
    logic                   csr_rsp_ready_i = 1'b1;
    logic [RW_N-1:0][31:0]  csr_reg_set_o;
    logic                   csr_reg_set_valid_o;
    logic                   csr_reg_set_ready_i = 1'b0;
    logic [RO_N-1:0][31:0]  csr_reg_ro_set_i = '0;

    int n_checks = 0;
    int n_errors = 0;
    int set_valid_cnt = 0;

    snax_dream_csr_manager #(
        .RegRWCount   (RW_N),
        .RegROCount   (RO_N),
        .RegDataWidth (32),
        .RegAddrWidth (32)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .csr_req_addr_i      (csr_req_addr_i),
        .csr_req_data_i      (csr_req_data_i),
        .csr_req_write_i     (csr_req_write_i),
        .csr_req_valid_i     (csr_req_valid_i),
        .csr_req_ready_o     (csr_req_ready_o),
        .csr_rsp_data_o      (csr_rsp_data_o),
        .csr_rsp_valid_o     (csr_rsp_valid_o),
        .csr_rsp_ready_i     (csr_rsp_ready_i),
        .csr_reg_set_o       (csr_reg_set_o),
        .csr_reg_set_valid_o (csr_reg_set_valid_o),
        .csr_reg_set_ready_i (csr_reg_set_ready_i),
        .csr_reg_ro_set_i    (csr_reg_ro_set_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (csr_reg_set_valid_o === 1'b1) set_valid_cnt <= set_valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one request and returns 1 time unit after the accepting edge.
    task automatic csr_issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int unsigned waited = 0;
        csr_req_valid_i = 1'b1;
        csr_req_write_i = wr;
        csr_req_addr_i  = addr;
        csr_req_data_i  = data;
        @(negedge clk_i);
        while (!csr_req_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        if (!csr_req_ready_o) check("req_accept_timeout", {31'b0, csr_req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        csr_req_valid_i = 1'b0;
        csr_req_write_i = 1'b0;
    endtask

    task automatic csr_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        csr_issue(1'b0, addr, 32'h0);
        @(negedge clk_i);
        check({tag, "_vld"}, {31'b0, csr_rsp_valid_o}, 32'd1);
        check(tag, csr_rsp_data_o, exp);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Reset and first post-reset cycle
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req_ready", {31'b0, csr_req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_ready", {31'b0, csr_req_ready_o}, 32'd1);
        check("rst_set_valid", {31'b0, csr_reg_set_valid_o}, 32'd0);
        check("rst_rsp_valid", {31'b0, csr_rsp_valid_o}, 32'd0);
        check("rst_rsp_data", csr_rsp_data_o, 32'd0);
        check("rst_reg1", csr_reg_set_o[1], 32'd0);
        @(posedge clk_i); #1;

        // RW write then read-back
        csr_issue(1'b1, 32'd1, 32'hA5);
        @(negedge clk_i);
        check("rw1_after_wr", csr_reg_set_o[1], 32'hA5);
        @(posedge clk_i); #1;
        csr_read(32'd1, 32'hA5, "rd_rw1");

        // RO reads, ignored writes, out-of-range
        csr_reg_ro_set_i[0] = 32'h1234;
        csr_reg_ro_set_i[1] = 32'hBEEF;
        csr_read(32'd3, 32'h1234, "rd_ro0");
        csr_read(32'd4, 32'hBEEF, "rd_ro1");
        csr_issue(1'b1, 32'd3, 32'hFF);
        csr_issue(1'b1, 32'd7, 32'h55);
        csr_read(32'd3, 32'h1234, "rd_ro0_after_wr");
        check("rw0_untouched", csr_reg_set_o[0], 32'd0);
        check("rw2_untouched", csr_reg_set_o[2], 32'd0);
        csr_read(32'd9, 32'd0, "rd_oor9");
        csr_read(PERF_ADR, 32'd0, "rd_s_plus1_idle");

        // Write to S with bit0 clear does nothing
        csr_issue(1'b1, S_ADR, 32'd2);
        @(negedge clk_i);
        check("s_bit0_clear_novalid", {31'b0, csr_reg_set_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        csr_read(S_ADR, 32'd0, "rd_s_idle");

        // Four-cycle launch with a stalled RW write
        base = set_valid_cnt;
        csr_issue(1'b1, S_ADR, 32'd1);
        csr_read(S_ADR, 32'd1, "rd_s_busy");
        csr_req_valid_i = 1'b1;
        csr_req_write_i = 1'b1;
        csr_req_addr_i  = 32'd0;
        csr_req_data_i  = 32'h77;
        @(negedge clk_i);
        check("stall_ready_a", {31'b0, csr_req_ready_o}, 32'd0);
        check("stall_reg0_stable", csr_reg_set_o[0], 32'd0);
        @(posedge clk_i); #1;
        csr_reg_set_ready_i = 1'b1;
        @(negedge clk_i);
        check("stall_ready_b", {31'b0, csr_req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        csr_reg_set_ready_i = 1'b0;
        @(negedge clk_i);
        check("launch_done_valid", {31'b0, csr_reg_set_valid_o}, 32'd0);
        check("stall_released", {31'b0, csr_req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        csr_req_valid_i = 1'b0;
        csr_req_write_i = 1'b0;
        @(negedge clk_i);
        check("stalled_wr_done", csr_reg_set_o[0], 32'h77);
        check("launch_valid_cycles", 32'(set_valid_cnt - base), 32'd4);
        @(posedge clk_i); #1;

        // Launch coinciding with ready: one-cycle valid
        base = set_valid_cnt;
        csr_reg_set_ready_i = 1'b1;
        csr_issue(1'b1, S_ADR, 32'd1);
        @(negedge clk_i);
        check("coinc_valid", {31'b0, csr_reg_set_valid_o}, 32'd1);
        @(posedge clk_i); #1;
        csr_reg_set_ready_i = 1'b0;
        @(negedge clk_i);
        check("coinc_valid_drop", {31'b0, csr_reg_set_valid_o}, 32'd0);
        check("coinc_valid_cycles", 32'(set_valid_cnt - base), 32'd1);
        @(posedge clk_i); #1;

        // Response backpressure
        csr_rsp_ready_i = 1'b0;
        csr_issue(1'b0, 32'd1, 32'h0);
        csr_req_valid_i = 1'b1;
        csr_req_addr_i  = 32'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("bp_rsp_valid", {31'b0, csr_rsp_valid_o}, 32'd1);
            check("bp_rsp_data", csr_rsp_data_o, 32'hA5);
            check("bp_req_ready", {31'b0, csr_req_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        csr_rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_ready", {31'b0, csr_req_ready_o}, 32'd1);
        check("bp_release_data", csr_rsp_data_o, 32'hA5);
        @(posedge clk_i); #1;
        csr_req_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_next_vld", {31'b0, csr_rsp_valid_o}, 32'd1);
        check("bp_next_data", csr_rsp_data_o, 32'h1234);
        @(posedge clk_i); #1;

        // Reset during launch with a pending response
        csr_issue(1'b1, S_ADR, 32'd1);
        csr_rsp_ready_i = 1'b0;
        csr_issue(1'b0, 32'd1, 32'h0);
        @(negedge clk_i);
        check("pre_rst_pending", {31'b0, csr_rsp_valid_o}, 32'd1);
        check("pre_rst_launch", {31'b0, csr_reg_set_valid_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("in_rst_ready", {31'b0, csr_req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("mid_rst_set_valid", {31'b0, csr_reg_set_valid_o}, 32'd0);
        check("mid_rst_rsp_valid", {31'b0, csr_rsp_valid_o}, 32'd0);
        check("mid_rst_rsp_data", csr_rsp_data_o, 32'd0);
        check("mid_rst_reg0", csr_reg_set_o[0], 32'd0);
        check("mid_rst_reg1", csr_reg_set_o[1], 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        csr_rsp_ready_i = 1'b1;
        csr_read(32'd0, 32'd0, "rd_rw0_post_rst");
        csr_read(32'd1, 32'd0, "rd_rw1_post_rst");
        csr_read(S_ADR, 32'd0, "rd_s_post_rst");

`ifdef SNAX_DREAM_CSR_PERF_EN
        // Five-cycle launch, then a one-cycle launch restarts the count
        csr_issue(1'b1, S_ADR, 32'd1);
        repeat (4) @(posedge clk_i);
        #1;
        csr_reg_set_ready_i = 1'b1;
        @(posedge clk_i); #1;
        csr_reg_set_ready_i = 1'b0;
        csr_read(PERF_ADR, 32'd5, "rd_perf_5");
        csr_reg_set_ready_i = 1'b1;
        csr_issue(1'b1, S_ADR, 32'd1);
        @(posedge clk_i); #1;
        csr_reg_set_ready_i = 1'b0;
        csr_read(PERF_ADR, 32'd1, "rd_perf_restart");
`else
        csr_read(PERF_ADR, 32'd0, "rd_s_plus1_oor");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
